// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard detection and forwarding control for the xgriscv in-order pipeline.
// A small scoreboard mirrors the instructions in flight behind decode
// (stage 1 = EX ... stage STAGES = WB). From it and the decode-stage
// instruction the block derives stalls, flushes and EX forward selects.
// It also handles a multi-cycle EX unit and counts load-use stalls and
// accepted redirects.
//
// Parameters
//   RFIDX_WIDTH  register index width
//   STAGES       tracked stages after decode (2..6)
//   LOAD_STAGE   first stage whose result is valid for a load (2..STAGES)
//   CNT_W        performance counter width
//   FWD_W        forward select width (derived)
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   id_*                       decode-stage instruction description
//   redirect                   taken branch/jump resolved in EX
//   ex_busy                    EX instruction needs another cycle
//   stall_f, stall_d           hold PC / IF-ID register
//   flush_d, flush_e           clear IF-ID / ID-EX register
//   fwd_a, fwd_b               EX operand source: 0 = regfile, k = stage k
//   stage_valid                bit k-1 = stage k occupied (debug view)
//   stall_count, flush_count   saturating event counters
//
// Control semantics: every output acts on the very next rising edge.
// A stall holds the addressed register for that edge; a flush loads it
// with a bubble on that edge. Flush wins over stall for the same register
// because the flushed contents are discarded anyway.
module hazard_ctrl #(
  parameter int RFIDX_WIDTH = 5,
  parameter int STAGES      = 3,
  parameter int LOAD_STAGE  = 3,
  parameter int CNT_W       = 16,
  parameter int FWD_W       = $clog2(STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [RFIDX_WIDTH-1:0] id_rs1,
  input  logic [RFIDX_WIDTH-1:0] id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [RFIDX_WIDTH-1:0] id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_load,
  input  logic                   redirect,
  input  logic                   ex_busy,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic [FWD_W-1:0]       fwd_a,
  output logic [FWD_W-1:0]       fwd_b,
  output logic [STAGES-1:0]      stage_valid,
  output logic [CNT_W-1:0]       stall_count,
  output logic [CNT_W-1:0]       flush_count
);

  // Scoreboard, indexed by stage number (1 = EX).
  logic [STAGES:1]        sValid;
  logic [STAGES:1]        sRegwrite;
  logic [STAGES:1]        sLoad;
  logic [RFIDX_WIDTH-1:0] sRd [1:STAGES];

  // Source operands of the instruction sitting in EX.
  logic [RFIDX_WIDTH-1:0] exRs1;
  logic [RFIDX_WIDTH-1:0] exRs2;
  logic                   exRs1Used;
  logic                   exRs2Used;

  logic redEff;
  logic loadUse;
  logic luHit;
  logic [FWD_W-1:0] fwdA;
  logic [FWD_W-1:0] fwdB;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // A producer matches a consumer source only when it really writes a
  // non-zero register and the consumer really reads it; x0 never matches.
  function automatic logic srcMatch(
    input logic                   v,
    input logic                   rw,
    input logic [RFIDX_WIDTH-1:0] rd,
    input logic [RFIDX_WIDTH-1:0] src,
    input logic                   used
  );
    return v && rw && (rd != '0) && (rd == src) && used;
  endfunction

  // A redirect is only accepted once the EX instruction has completed.
  assign redEff = redirect & ~ex_busy;

  // Load-use: a load that has not yet reached LOAD_STAGE cannot forward
  // in time for an instruction entering EX next cycle.
  always_comb begin
    luHit = 1'b0;
    for (int j = 1; j < LOAD_STAGE - 1; j++) begin
      if (sLoad[j] &&
          (srcMatch(sValid[j], sRegwrite[j], sRd[j], id_rs1, id_rs1_used) ||
           srcMatch(sValid[j], sRegwrite[j], sRd[j], id_rs2, id_rs2_used))) begin
        luHit = 1'b1;
      end
    end
  end

  assign loadUse = id_valid & luHit;

  assign stall_f = ex_busy | (loadUse & ~redEff);
  assign stall_d = stall_f;
  assign flush_d = redEff;
  // While EX is busy, ID/EX is held rather than bubbled, so a load-use
  // bubble is only inserted once EX is free.
  assign flush_e = redEff | (loadUse & ~ex_busy);

  // Scan from the oldest stage down so the youngest matching producer is
  // the one left in the select.
  always_comb begin
    fwdA = '0;
    fwdB = '0;
    for (int k = STAGES; k >= 2; k--) begin
      if (sValid[1] && srcMatch(sValid[k], sRegwrite[k], sRd[k], exRs1, exRs1Used)) begin
        fwdA = FWD_W'(k);
      end
      if (sValid[1] && srcMatch(sValid[k], sRegwrite[k], sRd[k], exRs2, exRs2Used)) begin
        fwdB = FWD_W'(k);
      end
    end
  end

  assign fwd_a = fwdA;
  assign fwd_b = fwdB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sValid    <= '0;
      sRegwrite <= '0;
      sLoad     <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        sRd[k] <= '0;
      end
      exRs1     <= '0;
      exRs2     <= '0;
      exRs1Used <= 1'b0;
      exRs2Used <= 1'b0;
    end else begin
      // Stages MEM+1 .. WB always advance.
      for (int k = 3; k <= STAGES; k++) begin
        sValid[k]    <= sValid[k-1];
        sRegwrite[k] <= sRegwrite[k-1];
        sLoad[k]     <= sLoad[k-1];
        sRd[k]       <= sRd[k-1];
      end
      if (ex_busy) begin
        // EX holds its instruction; MEM receives a bubble.
        sValid[2] <= 1'b0;
      end else begin
        sValid[2]    <= sValid[1];
        sRegwrite[2] <= sRegwrite[1];
        sLoad[2]     <= sLoad[1];
        sRd[2]       <= sRd[1];
        sValid[1]    <= id_valid & ~flush_e;
        sRegwrite[1] <= id_regwrite;
        sLoad[1]     <= id_load;
        sRd[1]       <= id_rd;
        exRs1        <= id_rs1;
        exRs2        <= id_rs2;
        exRs1Used    <= id_rs1_used;
        exRs2Used    <= id_rs2_used;
      end
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (loadUse && !redEff && !ex_busy && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
      if (redEff && (flushCnt != '1)) begin
        flushCnt <= flushCnt + 1'b1;
      end
    end
  end

  assign stall_count = stallCnt;
  assign flush_count = flushCnt;
  assign stage_valid = sValid;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int RFW = 5;
  localparam int STG = 3;
  localparam int LDS = 3;
  localparam int CW  = 3;
  localparam int FW  = 2;
  localparam int W   = 4 + 2 * FW + STG + 2 * CW;

  logic           clk = 1'b0;
  logic           reset;
  logic           id_valid;
  logic [RFW-1:0] id_rs1;
  logic [RFW-1:0] id_rs2;
  logic           id_rs1_used;
  logic           id_rs2_used;
  logic [RFW-1:0] id_rd;
  logic           id_regwrite;
  logic           id_load;
  logic           redirect;
  logic           ex_busy;
  logic           stall_f;
  logic           stall_d;
  logic           flush_d;
  logic           flush_e;
  logic [FW-1:0]  fwd_a;
  logic [FW-1:0]  fwd_b;
  logic [STG-1:0] stage_valid;
  logic [CW-1:0]  stall_count;
  logic [CW-1:0]  flush_count;

  hazard_ctrl #(
    .RFIDX_WIDTH(RFW),
    .STAGES(STG),
    .LOAD_STAGE(LDS),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(id_valid),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd(id_rd),
    .id_regwrite(id_regwrite),
    .id_load(id_load),
    .redirect(redirect),
    .ex_busy(ex_busy),
    .stall_f(stall_f),
    .stall_d(stall_d),
    .flush_d(flush_d),
    .flush_e(flush_e),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .stage_valid(stage_valid),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard: one entry per cycle; care=0 entries are not compared.
  logic [W-1:0] exp_q[$];
  bit           care_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  function automatic logic [W-1:0] e(
    input logic sf, input logic sd, input logic fd, input logic fe,
    input logic [FW-1:0] fa, input logic [FW-1:0] fb,
    input logic [STG-1:0] sv, input logic [CW-1:0] sc, input logic [CW-1:0] fc
  );
    return {sf, sd, fd, fe, fa, fb, sv, sc, fc};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    care_q.push_back(1'b1);
    name_q.push_back(nm);
  endtask

  task automatic skip();
    exp_q.push_back('0);
    care_q.push_back(1'b0);
    name_q.push_back("");
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(
    input logic v, input logic [RFW-1:0] rs1, input logic u1,
    input logic [RFW-1:0] rs2, input logic u2, input logic [RFW-1:0] rd,
    input logic rw, input logic ld, input logic red, input logic busy
  );
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_load     = ld;
    redirect    = red;
    ex_busy     = busy;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drv_lw();
    drv(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
  endtask

  task automatic drv_use(input logic red);
    drv(1, 5, 1, 1, 1, 7, 1, 0, red, 0);
  endtask

  // Monitor: compares one expected entry per cycle, away from the edge.
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    bit           c;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        c    = care_q.pop_front();
        nm   = name_q.pop_front();
        if (c) begin
          got = {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b,
                 stage_valid, stall_count, flush_count};
          n_checks++;
          if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got sf/sd/fd/fe=%b fa=%0d fb=%0d sv=%b sc=%0d fc=%0d, expected sf/sd/fd/fe=%b fa=%0d fb=%0d sv=%b sc=%0d fc=%0d",
                     nm, got[W-1 -: 4], got[W-5 -: FW], got[W-5-FW -: FW],
                     got[2*CW+STG-1 -: STG], got[2*CW-1 -: CW], got[CW-1:0],
                     want[W-1 -: 4], want[W-5 -: FW], want[W-5-FW -: FW],
                     want[2*CW+STG-1 -: STG], want[2*CW-1 -: CW], want[CW-1:0]);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    idle();
    repeat (2) begin cyc(); skip(); end
    reset = 1'b0;

    // Random activity to leave arbitrary state behind.
    for (int i = 0; i < 20; i++) begin
      cyc();
      drv($urandom_range(0, 1), RFW'($urandom_range(0, 7)), $urandom_range(0, 1),
          RFW'($urandom_range(0, 7)), $urandom_range(0, 1), RFW'($urandom_range(0, 7)),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3) == 0);
      skip();
    end

    // Reset mid-operation with EX busy, then release.
    cyc(); reset = 1'b1; idle(); ex_busy = 1'b1;
    chk("rst_busy", e(1, 1, 0, 0, 0, 0, 3'b000, 0, 0));
    cyc(); reset = 1'b0; idle();
    chk("rst_rel", e(0, 0, 0, 0, 0, 0, 3'b000, 0, 0));

    // ALU to ALU forwarding.
    cyc(); drv(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);  chk("alu_prod", e(0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    cyc(); drv(1, 5, 1, 5, 1, 6, 1, 0, 0, 0);  chk("alu_cons", e(0, 0, 0, 0, 0, 0, 3'b001, 0, 0));
    cyc(); idle();                             chk("fwd_mem",  e(0, 0, 0, 0, 2, 2, 3'b011, 0, 0));
    cyc(); drv(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);  chk("gap_prod", e(0, 0, 0, 0, 0, 0, 3'b110, 0, 0));
    cyc(); drv(1, 3, 1, 4, 1, 9, 1, 0, 0, 0);  chk("gap_ind",  e(0, 0, 0, 0, 0, 0, 3'b101, 0, 0));
    cyc(); drv(1, 8, 1, 8, 1, 10, 1, 0, 0, 0); chk("gap_cons", e(0, 0, 0, 0, 0, 0, 3'b011, 0, 0));
    cyc(); idle();                             chk("fwd_wb",   e(0, 0, 0, 0, 3, 3, 3'b111, 0, 0));
    cyc(); drv(1, 1, 1, 2, 1, 0, 1, 0, 0, 0);  chk("x0_prod",  e(0, 0, 0, 0, 0, 0, 3'b110, 0, 0));
    cyc(); drv(1, 0, 1, 0, 1, 11, 1, 0, 0, 0); chk("x0_cons",  e(0, 0, 0, 0, 0, 0, 3'b101, 0, 0));
    cyc(); idle();                             chk("x0_nofwd", e(0, 0, 0, 0, 0, 0, 3'b011, 0, 0));
    cyc(); idle();                             chk("drain1",   e(0, 0, 0, 0, 0, 0, 3'b110, 0, 0));
    cyc(); idle();                             chk("drain2",   e(0, 0, 0, 0, 0, 0, 3'b100, 0, 0));

    // Load-use: one stall cycle, then WB forwarding.
    cyc(); drv_lw();    chk("lu_load",  e(0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    cyc(); drv_use(0);  chk("lu_stall", e(1, 1, 0, 1, 0, 0, 3'b001, 0, 0));
    cyc(); drv_use(0);  chk("lu_go",    e(0, 0, 0, 0, 0, 0, 3'b010, 1, 0));
    cyc(); idle();      chk("lu_fwd",   e(0, 0, 0, 0, 3, 0, 3'b101, 1, 0));
    cyc(); idle();      chk("drain3",   e(0, 0, 0, 0, 0, 0, 3'b010, 1, 0));
    cyc(); idle();      chk("drain4",   e(0, 0, 0, 0, 0, 0, 3'b100, 1, 0));

    // Redirect beats load-use.
    cyc(); drv_lw();    chk("rd_load",  e(0, 0, 0, 0, 0, 0, 3'b000, 1, 0));
    cyc(); drv_use(1);  chk("rd_win",   e(0, 0, 1, 1, 0, 0, 3'b001, 1, 0));
    cyc(); idle();      chk("rd_after", e(0, 0, 0, 0, 0, 0, 3'b010, 1, 1));

    // Multi-cycle EX with an ignored redirect.
    cyc(); drv(1, 0, 0, 0, 0, 14, 1, 0, 0, 0);  chk("mc_pre",   e(0, 0, 0, 0, 0, 0, 3'b100, 1, 1));
    cyc(); drv(1, 1, 1, 2, 1, 12, 1, 0, 0, 0);  chk("mc_prod",  e(0, 0, 0, 0, 0, 0, 3'b001, 1, 1));
    cyc(); drv(1, 12, 1, 3, 1, 13, 1, 0, 1, 1); chk("mc_busy1", e(1, 1, 0, 0, 0, 0, 3'b011, 1, 1));
    cyc(); drv(1, 12, 1, 3, 1, 13, 1, 0, 1, 1); chk("mc_busy2", e(1, 1, 0, 0, 0, 0, 3'b101, 1, 1));
    cyc(); drv(1, 12, 1, 3, 1, 13, 1, 0, 1, 1); chk("mc_busy3", e(1, 1, 0, 0, 0, 0, 3'b001, 1, 1));
    cyc(); drv(1, 12, 1, 3, 1, 13, 1, 0, 0, 0); chk("mc_done",  e(0, 0, 0, 0, 0, 0, 3'b001, 1, 1));
    cyc(); idle();                              chk("mc_fwd",   e(0, 0, 0, 0, 2, 0, 3'b011, 1, 1));
    cyc(); idle();                              chk("drain5",   e(0, 0, 0, 0, 0, 0, 3'b110, 1, 1));
    cyc(); idle();                              chk("drain6",   e(0, 0, 0, 0, 0, 0, 3'b100, 1, 1));

    // Saturation: ten more load-use stalls on a 3-bit counter.
    for (int i = 0; i < 10; i++) begin
      cyc(); drv_lw(); skip();
      cyc(); drv_use(0);
      chk("sat_stall", e(1, 1, 0, 1, 0, 0, (i == 0) ? 3'b001 : 3'b011,
                         CW'((1 + i > 7) ? 7 : 1 + i), 1));
      cyc(); drv_use(0); skip();
    end
    cyc(); idle(); chk("sat_final", e(0, 0, 0, 0, 3, 0, 3'b101, 7, 1));

    cyc(); idle(); skip();
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
